// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, sequencer states and IR fields for the lab CPU
// Contents: opcode constants, state_t enum, IR field positions, strobe_t bundle.
package cpu_pkg;

  // ir[7:4] opcode map; codes not listed here decode to no strobe
  localparam logic [3:0] NOP_OP  = 4'h0;
  localparam logic [3:0] OP_IN   = 4'h2;
  localparam logic [3:0] OP_HALT = 4'h3;
  localparam logic [3:0] OP_OUT  = 4'h4;
  localparam logic [3:0] OP_MOVI = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JG   = 4'h8;
  localparam logic [3:0] OP_ADD  = 4'h9;
  localparam logic [3:0] OP_MOVA = 4'hC;
  localparam logic [3:0] OP_MOVB = 4'hD;
  localparam logic [3:0] OP_MOVC = 4'hE;
  localparam logic [3:0] OP_MOVD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // IR field positions: OPC = [7:4], DR = [3:2], SR = [1:0]
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int DR_MSB  = 3;
  localparam int DR_LSB  = 2;
  localparam int SR_MSB  = 1;
  localparam int SR_LSB  = 0;

  typedef struct packed {
    logic mova;
    logic movb;
    logic movc;
    logic movd;
    logic add;
    logic sub;
    logic jmp;
    logic jg;
    logic in1;
    logic out1;
    logic movi;
    logic halt;
  } strobe_t;

endpackage

// File: rtl/seq_decode_if.sv
// rtl/seq_decode_if.sv - signal bundle between seq_decode and con_signal/RAM/ALU
// master: sequencer side (drives ir, sm, strobes, g, halted, busy).
// slave : surrounding datapath side (drives run, step, ram_dout, sm_en, gf_en, g_in).
interface seq_decode_if;
  logic       run;
  logic       step;
  logic [7:0] ram_dout;
  logic       sm_en;
  logic       gf_en;
  logic       g_in;
  logic [7:0] ir;
  logic       sm;
  logic       mova, movb, movc, movd;
  logic       add, sub, jmp, jg;
  logic       in1, out1, movi, halt;
  logic       g;
  logic       halted;
  logic       busy;

  modport master (
    input  run, step, ram_dout, sm_en, gf_en, g_in,
    output ir, sm, mova, movb, movc, movd, add, sub, jmp, jg,
           in1, out1, movi, halt, g, halted, busy
  );

  modport slave (
    output run, step, ram_dout, sm_en, gf_en, g_in,
    input  ir, sm, mova, movb, movc, movd, add, sub, jmp, jg,
           in1, out1, movi, halt, g, halted, busy
  );
endinterface

// File: rtl/seq_decode_op_decode.sv
// rtl/seq_decode_op_decode.sv - combinational opcode to one-hot strobe decoder
// Ports: opc (ir[7:4]), exec (high only in EXEC), strb (12 one-hot strobes).
module op_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opc,
  input  logic       exec,
  output strobe_t    strb
);

  always_comb begin
    strb = '0;
    if (exec) begin
      case (opc)
        OP_IN:   strb.in1  = 1'b1;
        OP_HALT: strb.halt = 1'b1;
        OP_OUT:  strb.out1 = 1'b1;
        OP_MOVI: strb.movi = 1'b1;
        OP_SUB:  strb.sub  = 1'b1;
        OP_JMP:  strb.jmp  = 1'b1;
        OP_JG:   strb.jg   = 1'b1;
        OP_ADD:  strb.add  = 1'b1;
        OP_MOVA: strb.mova = 1'b1;
        OP_MOVB: strb.movb = 1'b1;
        OP_MOVC: strb.movc = 1'b1;
        OP_MOVD: strb.movd = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - fetch/execute sequencer, IR, step edge detect and G flag
// Ports: clk, rst_n (async active-low), bus (seq_decode_if.master): run/step
// control, ram_dout instruction byte, sm_en/gf_en/g_in from datapath; ir, sm,
// decoded strobes, g, halted, busy out.
module seq_decode (
  input  logic         clk,
  input  logic         rst_n,
  seq_decode_if.master bus
);
  import cpu_pkg::*;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       g_q, g_d;
  logic       step_d_q, step_d_d;
  logic       step_edge;
  logic       exec;
  strobe_t    strb;

  assign step_edge = bus.step & ~step_d_q;
  assign exec      = (state_q == ST_EXEC);

  op_decode u_op_decode (
    .opc  (ir_q[OPC_MSB:OPC_LSB]),
    .exec (exec),
    .strb (strb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ir_q     <= 8'h00;
      g_q      <= 1'b0;
      step_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      g_q      <= g_d;
      step_d_q <= step_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    g_d      = bus.gf_en ? bus.g_in : g_q;
    // step_d tracks step every cycle, so an edge seen outside IDLE is dropped
    step_d_d = bus.step;
    case (state_q)
      ST_IDLE: begin
        if (bus.run || step_edge) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
        ir_d    = bus.ram_dout;
      end
      ST_EXEC: begin
        // halt must win over sm_en: con_signal drops sm_en because of halt
        if (strb.halt)        state_d = ST_HALT;
        else if (!bus.sm_en)  state_d = ST_EXEC;
        else if (bus.run)     state_d = ST_FETCH;
        else                  state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ir     = ir_q;
  assign bus.sm     = (state_q != ST_FETCH);
  assign bus.g      = g_q;
  assign bus.halted = (state_q == ST_HALT);
  assign bus.busy   = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign bus.mova   = strb.mova;
  assign bus.movb   = strb.movb;
  assign bus.movc   = strb.movc;
  assign bus.movd   = strb.movd;
  assign bus.add    = strb.add;
  assign bus.sub    = strb.sub;
  assign bus.jmp    = strb.jmp;
  assign bus.jg     = strb.jg;
  assign bus.in1    = strb.in1;
  assign bus.out1   = strb.out1;
  assign bus.movi   = strb.movi;
  assign bus.halt   = strb.halt;

endmodule

// File: tb/tb_seq_decode.sv
// tb/tb_seq_decode.sv - directed table-driven bench for seq_decode
module tb_seq_decode;

  logic clk;
  logic rst_n;

  seq_decode_if bus ();

  seq_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe bit order: mova movb movc movd add sub jmp jg in1 out1 movi halt
  localparam logic [11:0] S_NONE = 12'h000;
  localparam logic [11:0] S_MOVA = 12'b1000_0000_0000;
  localparam logic [11:0] S_MOVB = 12'b0100_0000_0000;
  localparam logic [11:0] S_MOVC = 12'b0010_0000_0000;
  localparam logic [11:0] S_MOVD = 12'b0001_0000_0000;
  localparam logic [11:0] S_ADD  = 12'b0000_1000_0000;
  localparam logic [11:0] S_SUB  = 12'b0000_0100_0000;
  localparam logic [11:0] S_JMP  = 12'b0000_0010_0000;
  localparam logic [11:0] S_JG   = 12'b0000_0001_0000;
  localparam logic [11:0] S_IN1  = 12'b0000_0000_1000;
  localparam logic [11:0] S_OUT1 = 12'b0000_0000_0100;
  localparam logic [11:0] S_MOVI = 12'b0000_0000_0010;
  localparam logic [11:0] S_HALT = 12'b0000_0000_0001;

  logic [11:0] strb_now;
  assign strb_now = {bus.mova, bus.movb, bus.movc, bus.movd, bus.add, bus.sub,
                     bus.jmp, bus.jg, bus.in1, bus.out1, bus.movi, bus.halt};

  typedef struct packed {
    logic        run;
    logic        step;
    logic        sm_en;
    logic        gf_en;
    logic        g_in;
    logic [7:0]  ram;
    logic        e_sm;
    logic        e_busy;
    logic        e_halted;
    logic [7:0]  e_ir;
    logic [11:0] e_strb;
    logic        e_g;
  } vec_t;

  localparam int NV = 36;
  vec_t vt [NV];

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic r, input logic st, input logic se,
                              input logic ge, input logic gi, input logic [7:0] rd,
                              input logic esm, input logic eb, input logic eh,
                              input logic [7:0] eir, input logic [11:0] es,
                              input logic eg);
    vec_t v;
    v.run = r; v.step = st; v.sm_en = se; v.gf_en = ge; v.g_in = gi; v.ram = rd;
    v.e_sm = esm; v.e_busy = eb; v.e_halted = eh; v.e_ir = eir; v.e_strb = es;
    v.e_g = eg;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic esm,
                         input logic eb, input logic eh, input logic [7:0] eir,
                         input logic [11:0] es, input logic eg);
    chk({tag, ".sm"},     idx, {31'd0, bus.sm},     {31'd0, esm});
    chk({tag, ".busy"},   idx, {31'd0, bus.busy},   {31'd0, eb});
    chk({tag, ".halted"}, idx, {31'd0, bus.halted}, {31'd0, eh});
    chk({tag, ".ir"},     idx, {24'd0, bus.ir},     {24'd0, eir});
    chk({tag, ".strb"},   idx, {20'd0, strb_now},   {20'd0, es});
    chk({tag, ".g"},      idx, {31'd0, bus.g},      {31'd0, eg});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic st, input logic se,
                       input logic ge, input logic gi, input logic [7:0] rd);
    bus.run = r; bus.step = st; bus.sm_en = se; bus.gf_en = ge; bus.g_in = gi;
    bus.ram_dout = rd;
  endtask

  initial begin
    // single step, run stream with G, undefined opcode, run drop, sm_en hold,
    // remaining opcodes, then halt and ignored run/step in HALTED
    vt[0]  = mk(0,1,1,0,0,8'h96, 0,1,0,8'h00,S_NONE,0);
    vt[1]  = mk(0,1,1,0,0,8'h96, 1,1,0,8'h96,S_ADD ,0);
    vt[2]  = mk(0,1,1,0,0,8'h96, 1,0,0,8'h96,S_NONE,0);
    vt[3]  = mk(0,1,1,0,0,8'h96, 1,0,0,8'h96,S_NONE,0);
    vt[4]  = mk(0,0,1,0,0,8'h96, 1,0,0,8'h96,S_NONE,0);
    vt[5]  = mk(1,0,1,0,0,8'h62, 0,1,0,8'h96,S_NONE,0);
    vt[6]  = mk(1,0,1,0,0,8'h62, 1,1,0,8'h62,S_SUB ,0);
    vt[7]  = mk(1,0,1,1,1,8'h81, 0,1,0,8'h62,S_NONE,1);
    vt[8]  = mk(1,0,1,0,0,8'h81, 1,1,0,8'h81,S_JG  ,1);
    vt[9]  = mk(1,0,1,0,0,8'h00, 0,1,0,8'h81,S_NONE,1);
    vt[10] = mk(1,0,1,0,0,8'h00, 1,1,0,8'h00,S_NONE,1);
    vt[11] = mk(1,0,1,0,0,8'hA5, 0,1,0,8'h00,S_NONE,1);
    vt[12] = mk(1,0,1,0,0,8'hA5, 1,1,0,8'hA5,S_NONE,1);
    vt[13] = mk(1,0,1,0,0,8'hC0, 0,1,0,8'hA5,S_NONE,1);
    vt[14] = mk(0,0,1,0,0,8'hC0, 1,1,0,8'hC0,S_MOVA,1);
    vt[15] = mk(0,0,1,0,0,8'hC0, 1,0,0,8'hC0,S_NONE,1);
    vt[16] = mk(1,0,1,0,0,8'hD4, 0,1,0,8'hC0,S_NONE,1);
    vt[17] = mk(1,0,1,0,0,8'hD4, 1,1,0,8'hD4,S_MOVB,1);
    vt[18] = mk(1,0,0,0,0,8'hD4, 1,1,0,8'hD4,S_MOVB,1);
    vt[19] = mk(0,0,1,0,0,8'hD4, 1,0,0,8'hD4,S_NONE,1);
    vt[20] = mk(1,0,1,0,0,8'h21, 0,1,0,8'hD4,S_NONE,1);
    vt[21] = mk(1,0,1,0,0,8'h21, 1,1,0,8'h21,S_IN1 ,1);
    vt[22] = mk(1,0,1,0,0,8'h4F, 0,1,0,8'h21,S_NONE,1);
    vt[23] = mk(1,0,1,0,0,8'h4F, 1,1,0,8'h4F,S_OUT1,1);
    vt[24] = mk(1,0,1,0,0,8'h5A, 0,1,0,8'h4F,S_NONE,1);
    vt[25] = mk(1,0,1,0,0,8'h5A, 1,1,0,8'h5A,S_MOVI,1);
    vt[26] = mk(1,0,1,0,0,8'h73, 0,1,0,8'h5A,S_NONE,1);
    vt[27] = mk(1,0,1,0,0,8'h73, 1,1,0,8'h73,S_JMP ,1);
    vt[28] = mk(1,0,1,0,0,8'hE8, 0,1,0,8'h73,S_NONE,1);
    vt[29] = mk(1,0,1,0,0,8'hE8, 1,1,0,8'hE8,S_MOVC,1);
    vt[30] = mk(1,0,1,0,0,8'h30, 0,1,0,8'hE8,S_NONE,1);
    vt[31] = mk(1,0,1,0,0,8'h30, 1,1,0,8'h30,S_HALT,1);
    vt[32] = mk(1,0,0,0,0,8'h30, 1,0,1,8'h30,S_NONE,1);
    vt[33] = mk(1,1,1,0,0,8'h45, 1,0,1,8'h30,S_NONE,1);
    vt[34] = mk(0,0,1,0,0,8'h45, 1,0,1,8'h30,S_NONE,1);
    vt[35] = mk(0,1,1,0,0,8'h45, 1,0,1,8'h30,S_NONE,1);

    rst_n = 1'b0;
    drive(0,0,1,0,0,8'h00);
    repeat (3) tick();
    chk_all("in_reset", 0, 1,0,0,8'h00,S_NONE,0);

    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle", i, 1,0,0,8'h00,S_NONE,0);
    end

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].run, vt[i].step, vt[i].sm_en, vt[i].gf_en, vt[i].g_in, vt[i].ram);
      tick();
      chk_all("vec", i, vt[i].e_sm, vt[i].e_busy, vt[i].e_halted,
              vt[i].e_ir, vt[i].e_strb, vt[i].e_g);
    end

    // reset is the only way out of HALTED
    drive(0,0,1,0,0,8'h00);
    rst_n = 1'b0;
    #1;
    chk_all("halt_rst", 0, 1,0,0,8'h00,S_NONE,0);
    rst_n = 1'b1;

    // load G in IDLE, fetch a movd, start another fetch, reset mid-FETCH
    drive(0,0,1,1,1,8'h00);
    tick();
    chk_all("gload", 0, 1,0,0,8'h00,S_NONE,1);
    drive(1,0,1,0,0,8'hF0);
    tick();
    chk_all("mid", 0, 0,1,0,8'h00,S_NONE,1);
    tick();
    chk_all("mid", 1, 1,1,0,8'hF0,S_MOVD,1);
    drive(1,0,1,0,0,8'h9C);
    tick();
    chk_all("mid", 2, 0,1,0,8'hF0,S_NONE,1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 0, 1,0,0,8'h00,S_NONE,0);
    drive(0,0,1,0,0,8'h9C);
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("post_rst", 0, 1,0,0,8'h00,S_NONE,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
